// File: rtl/oped_axil_pkg.sv
// Shared types for the OPED AXI4-Lite register bank: response codes, FSM states, byte merge.
package oped_axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = strb[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/oped_axil_regfile_if.sv
// AXI4-Lite channel bundle between the OPED control-plane master and the register bank.
interface oped_axil_regfile_if;

    logic [31:0] S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/oped_axil_wr_ctrl.sv
// AW/W join FSM and B channel; emits a one-cycle register write request on an OKAY commit.
module oped_axil_wr_ctrl
    import oped_axil_pkg::*;
#(
    parameter int unsigned NREGS     = 16,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [31:0]               awaddr_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [31:0]               wdata_i,
    input  logic [3:0]                wstrb_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    output resp_t                     bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    output logic                      we_o,
    output logic [$clog2(NREGS)-2:0]  widx_o,
    output logic [31:0]               wdata_o,
    output logic [3:0]                wstrb_o
);

    localparam int unsigned IW = $clog2(NREGS);
    localparam int unsigned AW = IW + 2;

    wr_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    resp_t       bresp_q, bresp_d;

    logic        aw_hs, w_hs, commit, hit;
    logic [31:0] c_addr, c_data;
    logic [3:0]  c_strb;
    logic [IW-1:0] idx;
    resp_t       c_resp;
    logic        unused_addr;

    assign aw_hs = awvalid_i & awready_q;
    assign w_hs  = wvalid_i & wready_q;

    // The commit uses whichever half arrived earlier from the latch, the other live.
    assign c_addr = (state_q == W_HAVE_AW) ? addr_q : awaddr_i;
    assign c_data = (state_q == W_HAVE_W) ? data_q : wdata_i;
    assign c_strb = (state_q == W_HAVE_W) ? strb_q : wstrb_i;

    assign hit = (c_addr[31:AW] == ADDR_BASE[31:AW]);
    assign idx = c_addr[AW-1:2];
    assign unused_addr = ^awaddr_i[1:0];

    always_comb begin
        c_resp = RESP_OKAY;
        if (!hit) begin
            c_resp = RESP_DECERR;
        end else if (idx[IW-1]) begin
            c_resp = RESP_SLVERR;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        unique case (state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                wready_d  = 1'b1;
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    addr_d    = awaddr_i;
                    awready_d = 1'b0;
                    state_d   = W_HAVE_AW;
                end else if (w_hs) begin
                    data_d   = wdata_i;
                    strb_d   = wstrb_i;
                    wready_d = 1'b0;
                    state_d  = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs) commit = 1'b1;
            W_HAVE_W:  if (aw_hs) commit = 1'b1;
            W_RESP: begin
                if (bready_i) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    state_d   = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
        if (commit) begin
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = c_resp;
            state_d   = W_RESP;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= W_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign we_o      = commit && (c_resp == RESP_OKAY);
    assign widx_o    = idx[IW-2:0];
    assign wdata_o   = c_data;
    assign wstrb_o   = c_strb;

endmodule

// File: rtl/oped_axil_regfile.sv
// AXI4-Lite register bank: lower half RW control words, upper half RO status words.
// Optional per-register write strobe output enabled by defining OPED_AXIL_WPULSE_EN.
module oped_axil_regfile
    import oped_axil_pkg::*;
#(
    parameter int unsigned NREGS     = 16,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    oped_axil_regfile_if.slave       s_axi,
    output logic [32*NREGS/2-1:0]    CTRL_Q,
    input  logic [32*NREGS/2-1:0]    STATUS_I
`ifdef OPED_AXIL_WPULSE_EN
    ,
    output logic [NREGS/2-1:0]       WR_PULSE
`endif
);

    localparam int unsigned IW  = $clog2(NREGS);
    localparam int unsigned AW  = IW + 2;
    localparam int unsigned NRW = NREGS / 2;

    logic [NRW-1:0][31:0] ctrl_q, ctrl_d;
    logic                 we;
    logic [IW-2:0]        widx;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 awready, wready, bvalid;
    resp_t                bresp;

    oped_axil_wr_ctrl #(
        .NREGS     (NREGS),
        .ADDR_BASE (ADDR_BASE)
    ) u_wr_ctrl (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .awaddr_i  (s_axi.S_AXI_AWADDR),
        .awvalid_i (s_axi.S_AXI_AWVALID),
        .awready_o (awready),
        .wdata_i   (s_axi.S_AXI_WDATA),
        .wstrb_i   (s_axi.S_AXI_WSTRB),
        .wvalid_i  (s_axi.S_AXI_WVALID),
        .wready_o  (wready),
        .bresp_o   (bresp),
        .bvalid_o  (bvalid),
        .bready_i  (s_axi.S_AXI_BREADY),
        .we_o      (we),
        .widx_o    (widx),
        .wdata_o   (wdata),
        .wstrb_o   (wstrb)
    );

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp;

    always_comb begin
        ctrl_d = ctrl_q;
        if (we) begin
            ctrl_d[widx] = merge_bytes(ctrl_q[widx], wdata, wstrb);
        end
    end

    rd_state_e     rstate_q, rstate_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    resp_t         rresp_q, rresp_d;
    logic          ar_hs, r_hit;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_word;
    resp_t         r_resp;
    logic          unused_sig;

    assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;
    assign r_hit = (s_axi.S_AXI_ARADDR[31:AW] == ADDR_BASE[31:AW]);
    assign r_idx = s_axi.S_AXI_ARADDR[AW-1:2];
    assign unused_sig = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_ARADDR[1:0]};

    // Reads sample ctrl_q before this edge's write, so a same-edge read sees the old value.
    always_comb begin
        r_word = '0;
        r_resp = RESP_DECERR;
        if (r_hit) begin
            r_resp = RESP_OKAY;
            if (r_idx[IW-1]) begin
                r_word = STATUS_I[32*r_idx[IW-2:0] +: 32];
            end else begin
                r_word = ctrl_q[r_idx[IW-2:0]];
            end
        end
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_word;
                    rresp_d   = r_resp;
                    rstate_d  = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axi.S_AXI_RREADY) begin
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

`ifdef OPED_AXIL_WPULSE_EN
    logic [NRW-1:0] wr_pulse_q, wr_pulse_d;

    always_comb begin
        wr_pulse_d = '0;
        if (we) begin
            wr_pulse_d[widx] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign WR_PULSE = wr_pulse_q;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_q    <= '0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            ctrl_q    <= ctrl_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign CTRL_Q              = ctrl_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_oped_axil_regfile.sv
// Directed self-checking bench for oped_axil_regfile (NREGS=16, non-zero window base).
module tb_oped_axil_regfile;

    localparam logic [31:0] BASE = 32'h4000_0100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] ctrl_q;
    logic [255:0] status;
    logic [7:0][31:0] exp_ctrl;
    int           n_checks = 0;
    int           n_fail   = 0;
`ifdef OPED_AXIL_WPULSE_EN
    logic [7:0]   wr_pulse;
`endif

    oped_axil_regfile_if bus();

    oped_axil_regfile #(
        .NREGS     (16),
        .ADDR_BASE (BASE)
    ) dut (
        .ACLK     (clk),
        .ARESET   (rst),
        .s_axi    (bus),
        .CTRL_Q   (ctrl_q),
        .STATUS_I (status)
`ifdef OPED_AXIL_WPULSE_EN
        ,
        .WR_PULSE (wr_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] resp);
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_WVALID  = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk({tag, "_bvalid"}, bus.S_AXI_BVALID, 1);
        chk({tag, "_bresp"}, bus.S_AXI_BRESP, resp);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        chk({tag, "_bvalid_drop"}, bus.S_AXI_BVALID, 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] resp);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        chk({tag, "_rvalid"}, bus.S_AXI_RVALID, 1);
        chk({tag, "_rdata"}, bus.S_AXI_RDATA, d);
        chk({tag, "_rresp"}, bus.S_AXI_RRESP, resp);
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        chk({tag, "_rvalid_drop"}, bus.S_AXI_RVALID, 0);
    endtask

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        status   = '0;
        status[31:0]  = 32'hCAFE0001;
        status[127:96] = 32'h12345678;
        exp_ctrl = '0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_awready", bus.S_AXI_AWREADY, 0);
        chk("rst_arready", bus.S_AXI_ARREADY, 0);
        chk("rst_bvalid", bus.S_AXI_BVALID, 0);
        chk("rst_rvalid", bus.S_AXI_RVALID, 0);
        chk("rst_ctrl", ctrl_q, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rel_wready", bus.S_AXI_WREADY, 0);
        tick();
        chk("up_awready", bus.S_AXI_AWREADY, 1);
        chk("up_wready", bus.S_AXI_WREADY, 1);
        chk("up_arready", bus.S_AXI_ARREADY, 1);

        // 1: joint AW/W write then readback
        wr("t1_wr", BASE + 32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
        exp_ctrl[1] = 32'hDEADBEEF;
        chk("t1_ctrl", ctrl_q, exp_ctrl);
        rd("t1_rd", BASE + 32'h4, 32'hDEADBEEF, 2'b00);

        // 2: W three cycles ahead of AW, partial strobe
        bus.S_AXI_WDATA  = 32'h11223344;
        bus.S_AXI_WSTRB  = 4'b0101;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        chk("t2_wready_wait", bus.S_AXI_WREADY, 0);
        chk("t2_awready_wait", bus.S_AXI_AWREADY, 1);
        tick();
        tick();
        chk("t2_wready_wait2", bus.S_AXI_WREADY, 0);
        chk("t2_no_commit", ctrl_q, exp_ctrl);
        bus.S_AXI_AWADDR  = BASE;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        exp_ctrl[0] = 32'h00220044;
        chk("t2_ctrl", ctrl_q, exp_ctrl);
        chk("t2_bvalid", bus.S_AXI_BVALID, 1);
        chk("t2_bresp", bus.S_AXI_BRESP, 2'b00);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;

        // AW ahead of W, upper-byte strobe
        bus.S_AXI_AWADDR  = BASE + 32'h8;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        chk("aw1st_awready", bus.S_AXI_AWREADY, 0);
        chk("aw1st_wready", bus.S_AXI_WREADY, 1);
        bus.S_AXI_WDATA  = 32'hA5A5A5A5;
        bus.S_AXI_WSTRB  = 4'b1010;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        exp_ctrl[2] = 32'hA500A500;
        chk("aw1st_ctrl", ctrl_q, exp_ctrl);
        chk("aw1st_bresp", bus.S_AXI_BRESP, 2'b00);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;

        // 3: status words and SLVERR on RO write
        rd("t3_st0", BASE + 32'h20, 32'hCAFE0001, 2'b00);
        rd("t3_st3", BASE + 32'h2C, 32'h12345678, 2'b00);
        wr("t3_ro_wr", BASE + 32'h20, 32'h0BADBAD0, 4'hF, 2'b10);
        chk("t3_ctrl", ctrl_q, exp_ctrl);
        rd("t3_st0_again", BASE + 32'h20, 32'hCAFE0001, 2'b00);

        // 4: outside the window, and a base just below it
        rd("t4_rd_miss", BASE + 32'h40, 32'h0, 2'b11);
        wr("t4_wr_miss", BASE + 32'h40, 32'h77777777, 4'hF, 2'b11);
        wr("t4_wr_below", BASE - 32'h40 + 32'h4, 32'h66666666, 4'hF, 2'b11);
        chk("t4_ctrl", ctrl_q, exp_ctrl);

        // addr[1:0] ignored, WSTRB=0 is an OKAY no-op
        wr("lowbits_wr", BASE + 32'h0E, 32'h0BADF00D, 4'hF, 2'b00);
        exp_ctrl[3] = 32'h0BADF00D;
        wr("strb0_wr", BASE + 32'h7, 32'hFFFFFFFF, 4'h0, 2'b00);
        chk("lowbits_ctrl", ctrl_q, exp_ctrl);

        // Same-edge read and write of reg 1: read sees old value
        bus.S_AXI_AWADDR = BASE + 32'h4; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h13579BDF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = BASE + 32'h4; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        exp_ctrl[1] = 32'h13579BDF;
        chk("rw_same_rdata", bus.S_AXI_RDATA, 32'hDEADBEEF);
        chk("rw_same_ctrl", ctrl_q, exp_ctrl);
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;

        // 5: both responses stalled for 10 cycles with a new AW pending
        bus.S_AXI_AWADDR = BASE + 32'h10; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h44444444; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = BASE; bus.S_AXI_ARVALID = 1'b1;
        tick();
        exp_ctrl[4] = 32'h44444444;
        bus.S_AXI_AWADDR = BASE + 32'h14; bus.S_AXI_WDATA = 32'h55555555;
        bus.S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t5_bvalid", bus.S_AXI_BVALID, 1);
            chk("t5_bresp", bus.S_AXI_BRESP, 2'b00);
            chk("t5_rvalid", bus.S_AXI_RVALID, 1);
            chk("t5_rdata", bus.S_AXI_RDATA, 32'h00220044);
            chk("t5_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 0);
            tick();
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        chk("t5_ctrl", ctrl_q, exp_ctrl);
        chk("t5_valids_drop", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 0);

        // 6: reset while in W_HAVE_AW and R_RESP
        bus.S_AXI_AWADDR = BASE + 32'h8; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_ARADDR = BASE + 32'h4; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        chk("t6_pre_rvalid", bus.S_AXI_RVALID, 1);
        rst = 1'b1;
        #1;
        chk("t6_async_outs", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                              bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 0);
        chk("t6_ctrl_clr", ctrl_q, 0);
        exp_ctrl = '0;
        tick();
        rst = 1'b0;
        tick();
        bus.S_AXI_WDATA = 32'hFFFFFFFF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        chk("t6_aw_discarded", {bus.S_AXI_BVALID, ctrl_q}, 0);
        bus.S_AXI_AWADDR = BASE + 32'h8; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        exp_ctrl[2] = 32'hFFFFFFFF;
        chk("t6_ctrl", ctrl_q, exp_ctrl);
`ifdef OPED_AXIL_WPULSE_EN
        chk("t6_pulse", wr_pulse, 8'h04);
`endif
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
`ifdef OPED_AXIL_WPULSE_EN
        chk("t6_pulse_end", wr_pulse, 8'h00);
        bus.S_AXI_AWADDR = BASE + 32'h24; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        chk("slverr_no_pulse", wr_pulse, 8'h00);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oped_axil_regfile.md
# oped_axil_regfile

- AXI4-Lite slave (responder) register bank terminating the OPED control-plane master (AWADDR/WDATA/BRESP/ARADDR/RDATA channel set).
- Provides NREGS 32-bit registers:
  - lower half read/write control registers, driven out to fabric;
  - upper half read-only status words, sampled from fabric.
- Sits in the ACLK domain beside the OPED instance and is the first consumer of its 4GB AXI4-Lite window.

## Interface
Parameters:
- NREGS, 16, register count; power of two, 4..64. Index 0..NREGS/2-1 is RW; NREGS/2..NREGS-1 is RO.
- ADDR_BASE, 32'h0000_0000, byte base of the window; must be aligned to NREGS*4.

Ports (one clock; reset is asynchronous and active-high):
- ACLK  in  1  sole clock, rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  32/3/1  write address; AWPROT ignored.
- S_AXI_AWREADY  out  1  write-address accept.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data.
- S_AXI_WREADY  out  1  write-data accept.
- S_AXI_BRESP/BVALID  out  2/1  write response.
- S_AXI_BREADY  in  1  response accept.
- S_AXI_ARADDR/ARPROT/ARVALID  in  32/3/1  read address; ARPROT ignored.
- S_AXI_ARREADY  out  1  read-address accept.
- S_AXI_RDATA/RRESP/RVALID  out  32/2/1  read data.
- S_AXI_RREADY  in  1  read-data accept.
- CTRL_Q  out  32*NREGS/2  RW register contents; reg i at [32i+31:32i].
- STATUS_I  in  32*NREGS/2  RO words; word j maps to reg NREGS/2+j.
- WR_PULSE  out  NREGS/2  per-RW-reg write strobe. Present only with OPED_AXIL_WPULSE_EN.

## Operation
Address decode:
- Hit when addr[31:log2(NREGS*4)] equals ADDR_BASE's upper bits.
- Index is addr[log2(NREGS*4)-1:2]; addr[1:0] is ignored.

Responses:
- OKAY 2'b00: RW write, or any read hit.
- SLVERR 2'b10: write to an RO index. The write has no effect.
- DECERR 2'b11: miss, read or write. No effect; RDATA=0.

Byte lanes:
- WSTRB[k] set replaces byte k of the target register; clear bytes are retained.
- WSTRB=0 is a legal no-op with OKAY.

Write FSM (states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP):
- W_IDLE: AWREADY=WREADY=1.
  - AW handshake alone goes to W_HAVE_AW (address latched).
  - W handshake alone goes to W_HAVE_W (data and strobe latched).
  - Both in the same cycle commit the write and go to W_RESP.
- W_HAVE_AW: AWREADY=0, WREADY=1. W handshake commits and goes to W_RESP.
- W_HAVE_W: WREADY=0, AWREADY=1. AW handshake commits and goes to W_RESP.
- W_RESP: AWREADY=WREADY=0, BVALID=1 with BRESP held. BREADY takes the FSM to W_IDLE.
- Only one write is outstanding at a time.

Read FSM (states R_IDLE, R_RESP):
- R_IDLE: ARREADY=1. An AR handshake latches RDATA/RRESP and goes to R_RESP.
- R_RESP: ARREADY=0, RVALID=1 with RDATA/RRESP held stable. RREADY returns the FSM to R_IDLE.

Concurrency:
- Read and write FSMs run independently.
- A read and a write commit to the same register on the same edge: the read returns the pre-write value.
- STATUS_I is sampled on the AR handshake edge only.

## Timing
- Reset values, asserted asynchronously: all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, CTRL_Q 0, WR_PULSE 0, both FSMs in IDLE.
- AWREADY, WREADY and ARREADY rise on the first ACLK edge after ARESET deasserts.
- Write commit: CTRL_Q updates on the edge where the second of AW/W handshakes. BVALID is high from that edge. Response latency is 1 cycle.
- Read: RVALID/RDATA are valid one cycle after the AR handshake.
- Back-to-back throughput is one transaction per 2 cycles per direction when BREADY/RREADY are held high.
- VALID outputs never drop without the matching READY.
- ARESET mid-transaction:
  - pending BVALID/RVALID drop immediately;
  - latched AW/W are discarded;
  - no partial write commits.

## Configuration
- OPED_AXIL_WPULSE_EN defined:
  - WR_PULSE exists;
  - bit i is high for exactly one cycle, the commit cycle, on an OKAY write to RW reg i, including WSTRB=0;
  - SLVERR and DECERR writes produce no pulse.
- Undefined: the WR_PULSE port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package oped_axil_pkg:
  - resp constants RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - the 2-bit resp typedef;
  - the write-FSM and read-FSM state enums;
  - the byte-merge function (old, new, strb).
- One sub-module, oped_axil_wr_ctrl: the AW/W join FSM plus B channel.
- The read path and register array stay in the top.

## Test plan
1. Reset, then write 0xDEADBEEF to ADDR_BASE+0x4 with WSTRB=4'hF and AW/W in the same cycle -> BVALID next cycle with BRESP=00; CTRL_Q[63:32]=0xDEADBEEF; read back returns 0xDEADBEEF with OKAY.
2. W presented 3 cycles before AW, to reg 0, data 0x11223344, WSTRB=4'b0101 over an old value of 0 -> CTRL_Q[31:0]=0x00220044; WREADY=0 while waiting for AW.
3. NREGS=16, STATUS_I word 0=0xCAFE0001 -> read ADDR_BASE+0x20 returns 0xCAFE0001/OKAY; a write there returns SLVERR and the status is unchanged.
4. Read and write ADDR_BASE+0x40, outside the 16-reg window -> both DECERR; RDATA=0; CTRL_Q unchanged.
5. BREADY/RREADY held low for 10 cycles -> BVALID/RVALID and their data stay stable; AWREADY, WREADY and ARREADY stay 0; a new AWVALID is not accepted.
6. ARESET pulsed while in W_HAVE_AW and in R_RESP -> all VALID/READY outputs 0 asynchronously and CTRL_Q=0; with OPED_AXIL_WPULSE_EN, the next OKAY write to reg 2 gives WR_PULSE=0x04 for one cycle.
